barrel_shift_pipe: RTL and testbench

Parametrised successor to the 8-bit `barrel` rotator. It rotates or shifts a WIDTH-bit word by 0..WIDTH-1 positions in five modes and reports the last bit shifted out. A valid/ready handshake sits on both the load side and the result side. It sits in the datapath between operand registers and the ALU writeback mux, and an optional per-stage pipeline raises the clock rate.

---
 rtl/barrel_pkg.sv | 53 +++++
 rtl/barrel_stage.sv | 77 +++++++
 rtl/barrel_shift_pipe.sv | 77 +++++++
 tb/tb_barrel_shift_pipe.sv | 290 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/barrel_pkg.sv
// Shared types and reference model for barrel_shift_pipe (see BARREL_PIPE_EN in the top).
// Data and remaining sel travel next to stage_ctl_t because their widths follow WIDTH.
package barrel_pkg;

    typedef enum logic [2:0] {
        ROR  = 3'd0,
        ROL  = 3'd1,
        LSR  = 3'd2,
        LSL  = 3'd3,
        ASR  = 3'd4,
        PASS = 3'd5
    } mode_t;

    // Per-stage payload besides data/sel: operation, carry so far, valid
    typedef struct packed {
        mode_t mode;
        logic  carry;
        logic  valid;
    } stage_ctl_t;

    // Encodings 101..111 all collapse to pass-through
    function automatic mode_t decode_mode(input logic [2:0] m);
        return (m > 3'd4) ? PASS : mode_t'(m);
    endfunction

    // Reference result for widths up to 64: returns {carry, data[63:0]}
    function automatic logic [64:0] barrel_ref(input logic [63:0] d, input int w,
                                               input logic [2:0] mode, input int s);
        logic [63:0] mask;
        logic [63:0] dm;
        logic [63:0] r;
        logic        c;
        mask = (w >= 64) ? '1 : ((64'd1 << w) - 64'd1);
        dm   = d & mask;
        r    = dm;
        c    = 1'b0;
        if (s != 0) begin
            case (mode)
                ROR: begin r = ((dm >> s) | (dm << (w - s))) & mask; c = r[w-1]; end
                ROL: begin r = ((dm << s) | (dm >> (w - s))) & mask; c = r[0];   end
                LSR: begin r = dm >> s;                               c = dm[s-1]; end
                LSL: begin r = (dm << s) & mask;                      c = dm[w-s]; end
                ASR: begin
                    r = (dm >> s) | (dm[w-1] ? (mask & ~(mask >> s)) : 64'd0);
                    c = dm[s-1];
                end
                default: ;
            endcase
        end
        return {c, r};
    endfunction

endpackage

// File: rtl/barrel_stage.sv
// One log stage of barrel_shift_pipe: conditional 2**K shift/rotate with fill and carry.
// Registered when BARREL_PIPE_EN is defined, otherwise purely combinational.
module barrel_stage
    import barrel_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int K     = 0,
    parameter int SHW   = $clog2(WIDTH)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             advance,
    input  logic [WIDTH-1:0] in_data,
    input  logic [SHW-1:0]   in_sel,
    input  stage_ctl_t       in_ctl,
    output logic [WIDTH-1:0] out_data,
    output logic [SHW-1:0]   out_sel,
    output stage_ctl_t       out_ctl
);

    localparam int SH = 1 << K;

    logic [WIDTH-1:0] sh_data;
    stage_ctl_t       sh_ctl;

    // Carry is only replaced when this stage actually moves bits
    always_comb begin
        sh_data = in_data;
        sh_ctl  = in_ctl;
        if (in_sel[K]) begin
            case (in_ctl.mode)
                ROR: begin
                    sh_data      = {in_data[SH-1:0], in_data[WIDTH-1:SH]};
                    sh_ctl.carry = in_data[SH-1];
                end
                ROL: begin
                    sh_data      = {in_data[WIDTH-SH-1:0], in_data[WIDTH-1:WIDTH-SH]};
                    sh_ctl.carry = in_data[WIDTH-SH];
                end
                LSR: begin
                    sh_data      = {{SH{1'b0}}, in_data[WIDTH-1:SH]};
                    sh_ctl.carry = in_data[SH-1];
                end
                LSL: begin
                    sh_data      = {in_data[WIDTH-SH-1:0], {SH{1'b0}}};
                    sh_ctl.carry = in_data[WIDTH-SH];
                end
                ASR: begin
                    sh_data      = {{SH{in_data[WIDTH-1]}}, in_data[WIDTH-1:SH]};
                    sh_ctl.carry = in_data[SH-1];
                end
                default: ;
            endcase
        end
    end

`ifdef BARREL_PIPE_EN
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            out_data <= '0;
            out_sel  <= '0;
            out_ctl  <= '0;
        end else if (advance) begin
            out_data <= sh_data;
            out_sel  <= in_sel;
            out_ctl  <= sh_ctl;
        end
    end
`else
    logic unused_ok;
    assign unused_ok = ^{clk, reset, advance};
    assign out_data  = sh_data;
    assign out_sel   = in_sel;
    assign out_ctl   = sh_ctl;
`endif

endmodule

// File: rtl/barrel_shift_pipe.sv
// WIDTH-bit rotator/shifter built from SHW log stages with valid/ready on both sides.
// Define BARREL_PIPE_EN to register every stage (latency SHW); otherwise latency is 1.
module barrel_shift_pipe
    import barrel_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int SHW   = $clog2(WIDTH)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             load,
    output logic             ready,
    input  logic [2:0]       mode,
    input  logic [SHW-1:0]   sel,
    input  logic [WIDTH-1:0] data_in,
    output logic [WIDTH-1:0] data_out,
    output logic             carry,
    output logic             out_valid,
    input  logic             out_ready
);

    // Handshake: a word moves on a rising edge when its valid and ready are both high;
    // valids never wait on ready, and the whole pipe stalls while a result is unread.
    logic advance;
    assign advance = !out_valid || out_ready;
    assign ready   = advance;

    for (genvar k = 0; k < SHW; k++) begin : g_stage
        logic [WIDTH-1:0] d_i, d_o;
        logic [SHW-1:0]   s_i, s_o;
        stage_ctl_t       c_i, c_o;

        if (k == 0) begin : g_first
            assign d_i = data_in;
            assign s_i = sel;
            assign c_i = '{mode: decode_mode(mode), carry: 1'b0, valid: load};
        end else begin : g_chain
            assign d_i = g_stage[k-1].d_o;
            assign s_i = g_stage[k-1].s_o;
            assign c_i = g_stage[k-1].c_o;
        end

        barrel_stage #(.WIDTH(WIDTH), .K(k)) u_stage (
            .clk     (clk),
            .reset   (reset),
            .advance (advance),
            .in_data (d_i),
            .in_sel  (s_i),
            .in_ctl  (c_i),
            .out_data(d_o),
            .out_sel (s_o),
            .out_ctl (c_o)
        );
    end

`ifdef BARREL_PIPE_EN
    assign data_out  = g_stage[SHW-1].d_o;
    assign carry     = g_stage[SHW-1].c_o.carry;
    assign out_valid = g_stage[SHW-1].c_o.valid;
`else
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            data_out  <= '0;
            carry     <= 1'b0;
            out_valid <= 1'b0;
        end else if (advance) begin
            data_out  <= g_stage[SHW-1].d_o;
            carry     <= g_stage[SHW-1].c_o.carry;
            out_valid <= g_stage[SHW-1].c_o.valid;
        end
    end
`endif

    logic unused_ok;
    assign unused_ok = ^{g_stage[SHW-1].s_o, g_stage[SHW-1].c_o.mode};

endmodule

// File: tb/tb_barrel_shift_pipe.sv
// Self-checking bench for barrel_shift_pipe at WIDTH=8, either BARREL_PIPE_EN build.
module tb_barrel_shift_pipe;
  import barrel_pkg::*;

`ifdef BARREL_PIPE_EN
  localparam int L = 3;
`else
  localparam int L = 1;
`endif
  localparam logic [7:0] MODE_EXP [5] = '{8'h96, 8'hA5, 8'h16, 8'hA0, 8'hF6};

  logic       clk = 1'b0;
  logic       reset, load, ready, carry, out_valid, out_ready;
  logic [2:0] mode, sel;
  logic [7:0] data_in, data_out;

  int checks = 0;
  int failures = 0;
  int cyc = 0;

  logic [8:0]  exp_q[$];
  int          exp_cyc_q[$];
  logic [10:0] info_q[$];

  barrel_shift_pipe #(.WIDTH(8)) dut (
    .clk(clk), .reset(reset), .load(load), .ready(ready), .mode(mode), .sel(sel),
    .data_in(data_in), .data_out(data_out), .carry(carry), .out_valid(out_valid),
    .out_ready(out_ready)
  );

  // ---- clock / reset ----
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: got no end of run expected finish");
    $fatal(1, "watchdog");
  end

  // ---- reference model: bitwise index arithmetic, returns {carry, data} ----
  function automatic logic [8:0] model(input logic [7:0] d, input logic [2:0] md, input int s);
    logic [7:0] r;
    logic c;
    r = d;
    c = 1'b0;
    if (s != 0 && md <= 3'd4) begin
      for (int i = 0; i < 8; i++) begin
        case (md)
          3'd0: r[i] = d[(i + s) % 8];
          3'd1: r[i] = d[(i - s + 8) % 8];
          3'd2: r[i] = (i + s < 8) ? d[i + s] : 1'b0;
          3'd3: r[i] = (i >= s) ? d[i - s] : 1'b0;
          default: r[i] = (i + s < 8) ? d[i + s] : d[7];
        endcase
      end
      case (md)
        3'd0: c = r[7];
        3'd1: c = r[0];
        3'd3: c = d[8 - s];
        default: c = d[s - 1];
      endcase
    end
    return {c, r};
  endfunction

  // ---- driver: one cycle, inputs at negedge, outputs sampled 1 time unit later ----
  task automatic drive_cycle(input logic ld, input logic [2:0] md, input logic [2:0] s,
                             input logic [7:0] d, input logic ordy,
                             output logic ov, output logic rdy, output logic [7:0] dout,
                             output logic cout, output logic acc, output int at);
    logic [7:0] legacy;
    @(negedge clk);
    load = ld; mode = md; sel = s; data_in = d; out_ready = ordy;
    #1;
    ov = out_valid; rdy = ready; dout = data_out; cout = carry; at = cyc;
    acc = ld && ready;
    if (acc) begin
      legacy = (d >> s) | (d << (8 - s));
      exp_q.push_back(model(d, md, int'(s)));
      exp_cyc_q.push_back(cyc + L);
      info_q.push_back({md, legacy});
    end
    cyc++;
    @(posedge clk);
  endtask

  task automatic sb_pop(output logic [8:0] e, output int ec, output logic [10:0] info);
    e = exp_q.pop_front();
    ec = exp_cyc_q.pop_front();
    info = info_q.pop_front();
  endtask

  task automatic wait_result(output logic got, output logic [7:0] dout, output logic cout,
                             output int obs);
    logic ov, rdy, c, acc;
    logic [7:0] d;
    logic [8:0] e;
    logic [10:0] info;
    int at, ec;
    got = 1'b0; dout = '0; cout = 1'b0; obs = -1;
    for (int k = 0; k < 16 && !got; k++) begin
      drive_cycle(1'b0, 3'd0, 3'd0, 8'h00, 1'b1, ov, rdy, d, c, acc, at);
      if (ov) begin
        got = 1'b1; dout = d; cout = c; obs = at;
        if (exp_q.size() > 0) sb_pop(e, ec, info);
      end
    end
  endtask

  // ---- tests ----
  task automatic test_reset();
    logic ov, rdy, c, acc;
    logic [7:0] d;
    int at;
    #12;
    checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL reset_out_valid: got %b expected 0", out_valid); end
    checks++; if (data_out !== 8'h00) begin failures++; $display("FAIL reset_data_out: got %h expected 00", data_out); end
    checks++; if (carry !== 1'b0) begin failures++; $display("FAIL reset_carry: got %b expected 0", carry); end
    @(negedge clk);
    reset = 1'b1;
    drive_cycle(1'b0, 3'd0, 3'd0, 8'h00, 1'b1, ov, rdy, d, c, acc, at);
    checks++; if (rdy !== 1'b1) begin failures++; $display("FAIL reset_ready: got %b expected 1", rdy); end
    checks++; if (ov !== 1'b0) begin failures++; $display("FAIL reset_idle_valid: got %b expected 0", ov); end
  endtask

  task automatic test_modes();
    logic ov, rdy, c, acc, got, cout;
    logic [7:0] d, dout;
    int at, obs;
    for (int m = 0; m < 5; m++) begin
      drive_cycle(1'b1, 3'(m), 3'd3, 8'hB4, 1'b1, ov, rdy, d, c, acc, at);
      wait_result(got, dout, cout, obs);
      checks++; if (!got) begin failures++; $display("FAIL mode%0d_timeout: got none expected result", m); end
      checks++; if (dout !== MODE_EXP[m]) begin failures++; $display("FAIL mode%0d_data: got %h expected %h", m, dout, MODE_EXP[m]); end
      checks++; if (cout !== 1'b1) begin failures++; $display("FAIL mode%0d_carry: got %b expected 1", m, cout); end
      checks++; if (obs - at !== L) begin failures++; $display("FAIL mode%0d_latency: got %0d expected %0d", m, obs - at, L); end
    end
  endtask

  task automatic test_passthrough();
    logic ov, rdy, c, acc, got, cout;
    logic [7:0] d, dout;
    int at, obs;
    for (int m = 0; m < 8; m++) begin
      drive_cycle(1'b1, 3'(m), (m > 4) ? 3'd5 : 3'd0, 8'h5A, 1'b1, ov, rdy, d, c, acc, at);
      wait_result(got, dout, cout, obs);
      checks++; if (!got) begin failures++; $display("FAIL pass%0d_timeout: got none expected result", m); end
      checks++; if (dout !== 8'h5A) begin failures++; $display("FAIL pass%0d_data: got %h expected 5a", m, dout); end
      checks++; if (cout !== 1'b0) begin failures++; $display("FAIL pass%0d_carry: got %b expected 0", m, cout); end
    end
  endtask

  task automatic test_back_to_back();
    logic ov, rdy, c, acc;
    logic [7:0] d, din;
    logic [2:0] md;
    logic [8:0] e;
    logic [10:0] info;
    logic [64:0] pk;
    int at, ec;
    for (int i = 0; i < 40 + L + 3; i++) begin
      md = 3'($urandom_range(7));
      din = 8'($urandom);
      drive_cycle(i < 40, md, 3'(i % 8), din, 1'b1, ov, rdy, d, c, acc, at);
      checks++; if (rdy !== 1'b1) begin failures++; $display("FAIL b2b_ready: got %b expected 1", rdy); end
      if (i < 40) begin
        pk = barrel_ref({56'd0, din}, 8, md, i % 8);
        checks++;
        if ({pk[64], pk[7:0]} !== model(din, md, i % 8)) begin
          failures++; $display("FAIL pkg_ref: got %h expected %h", {pk[64], pk[7:0]}, model(din, md, i % 8));
        end
      end
      if (ov) begin
        checks++;
        if (exp_q.size() == 0) begin failures++; $display("FAIL b2b_extra: got %h expected no result", d); end
        else begin
          sb_pop(e, ec, info);
          checks++; if (d !== e[7:0]) begin failures++; $display("FAIL b2b_data: got %h expected %h", d, e[7:0]); end
          checks++; if (c !== e[8]) begin failures++; $display("FAIL b2b_carry: got %b expected %b", c, e[8]); end
          checks++; if (at !== ec) begin failures++; $display("FAIL b2b_cycle: got %0d expected %0d", at, ec); end
          if (info[10:8] == 3'd0) begin
            checks++; if (d !== info[7:0]) begin failures++; $display("FAIL b2b_legacy_ror: got %h expected %h", d, info[7:0]); end
          end
        end
      end
    end
    checks++; if (exp_q.size() != 0) begin failures++; $display("FAIL b2b_drain: got %0d left expected 0", exp_q.size()); end
  endtask

  task automatic test_stall();
    logic ov, rdy, c, acc, ordy;
    logic [7:0] d, hold;
    logic [8:0] e;
    logic [10:0] info;
    int at, ec;
    hold = '0;
    for (int i = 0; i < 24; i++) begin
      ordy = !(i >= 6 && i < 10);
      drive_cycle(i < 14, 3'($urandom_range(4)), 3'($urandom_range(7)), 8'($urandom), ordy,
                  ov, rdy, d, c, acc, at);
      if (!ordy) begin
        if (i == 6) begin
          hold = d;
          checks++; if (ov !== 1'b1) begin failures++; $display("FAIL stall_valid: got %b expected 1", ov); end
        end
        checks++; if (rdy !== 1'b0) begin failures++; $display("FAIL stall_ready: got %b expected 0", rdy); end
        checks++; if (d !== hold) begin failures++; $display("FAIL stall_hold: got %h expected %h", d, hold); end
      end else if (ov) begin
        checks++;
        if (exp_q.size() == 0) begin failures++; $display("FAIL stall_extra: got %h expected no result", d); end
        else begin
          sb_pop(e, ec, info);
          checks++; if (d !== e[7:0]) begin failures++; $display("FAIL stall_data: got %h expected %h", d, e[7:0]); end
          checks++; if (c !== e[8]) begin failures++; $display("FAIL stall_carry: got %b expected %b", c, e[8]); end
        end
      end
    end
    checks++; if (exp_q.size() != 0) begin failures++; $display("FAIL stall_drain: got %0d left expected 0", exp_q.size()); end
  endtask

  task automatic test_bubbles();
    logic ov, rdy, c, acc, exp_v;
    logic [7:0] d;
    logic [8:0] e;
    logic [10:0] info;
    logic ld_hist [32];
    int at, ec;
    for (int i = 0; i < 16 + L + 2; i++) begin
      ld_hist[i] = (i < 16) && (i % 2 == 0);
      drive_cycle(ld_hist[i], 3'($urandom_range(7)), 3'($urandom_range(7)), 8'($urandom), 1'b1,
                  ov, rdy, d, c, acc, at);
      exp_v = (i >= L) ? ld_hist[i - L] : 1'b0;
      checks++; if (ov !== exp_v) begin failures++; $display("FAIL bubble_valid%0d: got %b expected %b", i, ov, exp_v); end
      if (ov && exp_q.size() > 0) begin
        sb_pop(e, ec, info);
        checks++; if ({c, d} !== e) begin failures++; $display("FAIL bubble_data: got %h expected %h", {c, d}, e); end
      end
    end
    checks++; if (exp_q.size() != 0) begin failures++; $display("FAIL bubble_drain: got %0d left expected 0", exp_q.size()); end
  endtask

  task automatic test_reset_midstream();
    logic ov, rdy, c, acc, got, cout;
    logic [7:0] d, dout;
    logic [8:0] e, want;
    logic [10:0] info;
    int at, ec, obs;
    drive_cycle(1'b1, 3'd0, 3'd1, 8'hB4, 1'b1, ov, rdy, d, c, acc, at);
    drive_cycle(1'b1, 3'd3, 3'd2, 8'h3C, 1'b1, ov, rdy, d, c, acc, at);
    if (ov && exp_q.size() > 0) begin
      sb_pop(e, ec, info);
      checks++; if ({c, d} !== e) begin failures++; $display("FAIL rst_pre_data: got %h expected %h", {c, d}, e); end
    end
    #2;
    reset = 1'b0;
    #1;
    checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL rst_async_valid: got %b expected 0", out_valid); end
    checks++; if (data_out !== 8'h00) begin failures++; $display("FAIL rst_async_data: got %h expected 00", data_out); end
    checks++; if (carry !== 1'b0) begin failures++; $display("FAIL rst_async_carry: got %b expected 0", carry); end
    exp_q.delete(); exp_cyc_q.delete(); info_q.delete();
    load = 1'b0;
    @(negedge clk);
    reset = 1'b1;
    for (int i = 0; i < L + 3; i++) begin
      drive_cycle(1'b0, 3'd0, 3'd0, 8'h00, 1'b1, ov, rdy, d, c, acc, at);
      checks++; if (ov !== 1'b0) begin failures++; $display("FAIL rst_stale: got %b expected 0", ov); end
    end
    want = model(8'h81, 3'd4, 2);
    drive_cycle(1'b1, 3'd4, 3'd2, 8'h81, 1'b1, ov, rdy, d, c, acc, at);
    wait_result(got, dout, cout, obs);
    checks++; if (!got) begin failures++; $display("FAIL rst_first_timeout: got none expected result"); end
    checks++; if ({cout, dout} !== want) begin failures++; $display("FAIL rst_first_data: got %h expected %h", {cout, dout}, want); end
    checks++; if (obs - at !== L) begin failures++; $display("FAIL rst_first_latency: got %0d expected %0d", obs - at, L); end
  endtask

  // ---- sequence and report ----
  initial begin
    reset = 1'b0; load = 1'b0; mode = '0; sel = '0; data_in = '0; out_ready = 1'b1;
    test_reset();
    test_modes();
    test_passthrough();
    test_back_to_back();
    test_stall();
    test_bubbles();
    test_reset_midstream();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
